// File: rtl/divreg_pkg.sv
// rtl/divreg_pkg.sv - shared FSM encodings and width helper for the restoring divider
package divreg_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Smallest w with 2**w >= value; sizes the iteration counter so it can hold N
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/divreg_if.sv
// rtl/divreg_if.sv - operand and result handshake bundle for the divider
interface divreg_if #(parameter int N = 8);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         div0;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, div0
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, div0
    );

endinterface

// File: rtl/divreg_step.sv
// rtl/divreg_step.sv - one combinational restoring-division step
module divreg_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] dvd_in,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_out,
    output logic [N-1:0] dvd_out,
    output logic         qbit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    // Shift the next dividend bit into the remainder and keep the trial
    // subtraction only when it does not go negative
    always_comb begin
        shifted = {rem_in, dvd_in[N-1]};
        trial   = shifted - {2'b00, dvs};
        qbit    = ~trial[N+1];
        rem_out = qbit ? trial[N:0] : shifted[N:0];
        dvd_out = {dvd_in[N-2:0], 1'b0};
    end

endmodule

// File: rtl/divreg.sv
// rtl/divreg.sv - iterative radix-2 restoring divider with valid/ready in and out
module divreg
    import divreg_pkg::*;
#(
    parameter int N      = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic     clk,
    input  logic     nreset,
    divreg_if.slave  bus
);

    localparam int CW = clog2(N + 1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic [N-1:0]  a_hold;
    logic          neg_q;
    logic          neg_r;
    logic          zero_div;
    logic          ovf;
    logic [N:0]    rem_step;
    logic [N-1:0]  dvd_step;
    logic          qbit;
    logic          accept;
    logic          last_iter;
    logic          a_neg;
    logic          b_neg;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  r_reg;
    logic          div0_reg;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt == CW'(N));
    assign a_neg     = SIGNED && bus.a[N-1];
    assign b_neg     = SIGNED && bus.b[N-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    divreg_step #(.N(N)) u_step (
        .rem_in  (rem),
        .dvd_in  (dvd),
        .dvs     (dvs),
        .rem_out (rem_step),
        .dvd_out (dvd_step),
        .qbit    (qbit)
    );

    // Restore signs on the magnitude result; zero divisor and signed overflow override
    always_comb begin
        q_fix = neg_q ? -dvd : dvd;
        r_fix = neg_r ? -rem[N-1:0] : rem[N-1:0];
        if (zero_div) begin
            q_fix = '1;
            r_fix = a_hold;
        end else if (ovf) begin
            q_fix = a_hold;
            r_fix = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one extra CALC cycle after the N iterations registers the sign-fixed result
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = CALC;
            CALC:    if (last_iter)    state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Operand capture, shift/subtract iterations and result hold registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            a_hold   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            ovf      <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            div0_reg <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= a_mag;
            dvs      <= b_mag;
            a_hold   <= bus.a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_div <= (bus.b == '0);
            ovf      <= SIGNED && (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1);
        end else if (state == CALC) begin
            if (!last_iter) begin
                rem <= rem_step;
                dvd <= dvd_step | {{(N-1){1'b0}}, qbit};
                cnt <= cnt + 1'b1;
            end else begin
                q_reg    <= q_fix;
                r_reg    <= r_fix;
                div0_reg <= zero_div;
            end
        end
    end

    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.div0 = div0_reg;

endmodule

// File: tb/tb_divreg.sv
// tb/tb_divreg.sv - randomized self-checking bench for unsigned and signed divreg
module tb_divreg;

    localparam int N = 8;

    logic clk = 1'b0;
    logic nreset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    divreg_if #(.N(N)) us_if ();
    divreg_if #(.N(N)) sg_if ();

    divreg #(.N(N), .SIGNED(1'b0)) u_uns (.clk(clk), .nreset(nreset), .bus(us_if.slave));
    divreg #(.N(N), .SIGNED(1'b1)) u_sgn (.clk(clk), .nreset(nreset), .bus(sg_if.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {div0, q, r}
    function automatic logic [2*N:0] model_uns(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == 0) return {1'b1, 8'hFF, a};
        return {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    function automatic logic [2*N:0] model_sgn(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb, qi, ri;
        logic [N-1:0] qv, rv;
        if (b == 0) return {1'b1, 8'hFF, a};
        if (a == 8'h80 && b == 8'hFF) return {1'b0, 8'h80, 8'h00};
        sa = $signed(a);
        sb = $signed(b);
        qi = sa / sb;
        ri = sa % sb;
        qv = qi[N-1:0];
        rv = ri[N-1:0];
        return {1'b0, qv, rv};
    endfunction

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        us_if.in_valid = v; us_if.a = a; us_if.b = b;
        sg_if.in_valid = v; sg_if.a = a; sg_if.b = b;
    endtask

    task automatic set_ready(input logic v);
        us_if.out_ready = v;
        sg_if.out_ready = v;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int cycles;
        logic [2*N:0] eu, es;
        eu = model_uns(a, b);
        es = model_sgn(a, b);
        @(negedge clk);
        set_ready(1'b0);
        drive(1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, N'($urandom), N'($urandom));
        cycles = 0;
        while (!sg_if.out_valid && cycles < 40) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, N + 1);
        check("uns_valid", us_if.out_valid, 1'b1);
        check("uns_q", us_if.q, eu[2*N-1:N]);
        check("uns_r", us_if.r, eu[N-1:0]);
        check("uns_div0", us_if.div0, eu[2*N]);
        check("sgn_q", sg_if.q, es[2*N-1:N]);
        check("sgn_r", sg_if.r, es[N-1:0]);
        check("sgn_div0", sg_if.div0, es[2*N]);
    endtask

    task automatic release_out();
        @(negedge clk);
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(1'b0);
        check("rel_in_ready", {us_if.in_ready, sg_if.in_ready}, 2'b11);
        check("rel_out_valid", {us_if.out_valid, sg_if.out_valid}, 2'b00);
    endtask

    initial begin
        logic [N-1:0] da [5];
        logic [N-1:0] db [5];
        logic [N-1:0] ra, rb;
        da = '{8'd200, 8'hF9, 8'h07, 8'h55, 8'h80};
        db = '{8'd7,   8'h02, 8'hFE, 8'h00, 8'hFF};

        nreset = 1'b0;
        drive(1'b0, '0, '0);
        set_ready(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {us_if.in_ready, sg_if.in_ready}, 2'b11);
        check("rst_out_valid", {us_if.out_valid, sg_if.out_valid}, 2'b00);
        check("rst_q", {us_if.q, sg_if.q}, 16'h0);
        check("rst_r", {us_if.r, sg_if.r}, 16'h0);
        check("rst_div0", {us_if.div0, sg_if.div0}, 2'b00);
        nreset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(da[i], db[i]);
            release_out();
        end

        // Backpressure: results held, new requests ignored while DONE
        run_op(8'hF9, 8'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, N'($urandom), N'($urandom));
            @(posedge clk);
            @(negedge clk);
            check("bp_q", sg_if.q, 8'hFD);
            check("bp_r", sg_if.r, 8'hFF);
            check("bp_uns_q", us_if.q, 8'd124);
            check("bp_in_ready", {us_if.in_ready, sg_if.in_ready}, 2'b00);
            check("bp_out_valid", {us_if.out_valid, sg_if.out_valid}, 2'b11);
        end
        drive(1'b0, '0, '0);
        release_out();

        // Reset during the third iteration aborts the operation
        @(negedge clk);
        drive(1'b1, 8'h55, 8'h03);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("abort_out_valid", {us_if.out_valid, sg_if.out_valid}, 2'b00);
        check("abort_in_ready", {us_if.in_ready, sg_if.in_ready}, 2'b11);
        @(negedge clk);
        nreset = 1'b1;
        run_op(8'd100, 8'd10);
        release_out();

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: rb = N'($urandom_range(1, 3));
                default: ;
            endcase
            run_op(ra, rb);
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
